addr_sreg_tx: RTL and testbench



---
 rtl/addr_sreg_tx.sv | 189 ++++++++++++++++++
 tb/tb_addr_sreg_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr_sreg_tx.sv
// rtl/addr_sreg_tx.sv - serial SRAM address transmitter with shift clock and increment strobe (optional shadow: ADDR_SREG_TX_SHADOW_EN)
module addr_sreg_tx #(
    parameter int ADDR_W = 21,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              inc,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              si,
    output logic              sclk,
    output logic              sreg_en_n,
    output logic              counter_n,
    output logic [ADDR_W-1:0] shadow_addr
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(ADDR_W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        TAIL   = 3'd2,
        STROBE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] shift_reg;
    logic [CW-1:0]     bit_cnt;
    logic [DW-1:0]     div_cnt;
    logic              phase_hi;
    logic              div_end;
    logic              last_bit;

    assign div_end  = (div_cnt == DW'(DIV - 1));
    assign last_bit = (bit_cnt == CW'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start has priority over inc; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end else if (inc) begin
                    state_nxt = STROBE;
                end
            end
            SHIFT: begin
                if (div_end && phase_hi && last_bit) begin
                    state_nxt = TAIL;
                end
            end
            TAIL: begin
                if (div_end) begin
                    state_nxt = DONE;
                end
            end
            STROBE: begin
                if (div_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: phase timer, bit counter and shift register. The last bit is not
    // shifted out so that si keeps holding it through TAIL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            phase_hi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    phase_hi <= 1'b0;
                    if (start) begin
                        shift_reg <= addr;
                        bit_cnt   <= CW'(ADDR_W);
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        phase_hi <= ~phase_hi;
                        if (phase_hi) begin
                            bit_cnt <= bit_cnt - CW'(1);
                            if (!last_bit) begin
                                shift_reg <= shift_reg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                TAIL, STROBE: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                end
                default: begin
                    div_cnt  <= '0;
                    phase_hi <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDR_SREG_TX_SHADOW_EN
    logic [ADDR_W-1:0] cap_addr;
    logic [ADDR_W-1:0] shadow_q;

    // Local copy of the receiver's address: loaded when a shift completes, bumped per strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_addr <= '0;
            shadow_q <= '0;
        end else begin
            if (state == IDLE && start) begin
                cap_addr <= addr;
            end
            if (state == TAIL && div_end) begin
                shadow_q <= cap_addr;
            end else if (state == STROBE && div_end) begin
                shadow_q <= shadow_q + ADDR_W'(1);
            end
        end
    end

    assign shadow_addr = shadow_q;
`else
    assign shadow_addr = '0;
`endif

    // Outputs decoded from state so reset forces them idle immediately
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        si        = 1'b0;
        sclk      = 1'b0;
        sreg_en_n = 1'b1;
        counter_n = 1'b1;
        case (state)
            SHIFT: begin
                busy      = 1'b1;
                sreg_en_n = 1'b0;
                si        = shift_reg[ADDR_W-1];
                sclk      = phase_hi;
            end
            TAIL: begin
                busy      = 1'b1;
                sreg_en_n = 1'b0;
                si        = shift_reg[ADDR_W-1];
            end
            STROBE: begin
                busy      = 1'b1;
                counter_n = 1'b0;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_addr_sreg_tx.sv
// tb/tb_addr_sreg_tx.sv - self-checking bench for addr_sreg_tx
module tb_addr_sreg_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        inc = 1'b0;
    logic [20:0] addr = '0;
    logic        busy, done, si, sclk, sreg_en_n, counter_n;
    logic [20:0] shadow_addr;

    logic        start1 = 1'b0;
    logic        inc1 = 1'b0;
    logic [20:0] addr1 = '0;
    logic        busy1, done1, si1, sclk1, sreg_en_n1, counter_n1;
    logic [20:0] shadow_addr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_sreg_tx #(.ADDR_W(21), .DIV(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .inc(inc), .addr(addr),
        .busy(busy), .done(done), .si(si), .sclk(sclk), .sreg_en_n(sreg_en_n),
        .counter_n(counter_n), .shadow_addr(shadow_addr)
    );

    addr_sreg_tx #(.ADDR_W(21), .DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .inc(inc1), .addr(addr1),
        .busy(busy1), .done(done1), .si(si1), .sclk(sclk1), .sreg_en_n(sreg_en_n1),
        .counter_n(counter_n1), .shadow_addr(shadow_addr1)
    );

    typedef struct {
        logic        st;
        logic        in;
        logic [20:0] addr;
        int          repulse;
        logic [20:0] exp_bits;
        int          exp_nbits;
        int          exp_busy;
        int          exp_ctr;
        int          exp_en;
        logic [20:0] exp_shadow;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] shadow_exp(input logic [20:0] v);
`ifdef ADDR_SREG_TX_SHADOW_EN
        return v;
`else
        return 21'h0 & v;
`endif
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int          busy_c = 0;
        int          ctr_c = 0;
        int          en_c = 0;
        int          nbits = 0;
        int          viol = 0;
        logic [20:0] bits = '0;
        logic        got_done = 1'b0;
        logic        ps = 1'b0;
        logic        psi = 1'b0;
        logic [20:0] sh = '0;
        @(negedge clk);
        start = v.st;
        inc   = v.in;
        addr  = v.addr;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = (cyc == v.repulse);
            inc   = 1'b0;
            addr  = (cyc == v.repulse) ? 21'h0 : ~v.addr;
            if (busy) busy_c++;
            if (!counter_n) ctr_c++;
            if (!sreg_en_n) en_c++;
            if (sclk && !ps) begin
                bits = {bits[19:0], si};
                nbits++;
            end
            if (sclk && ps && (si != psi)) viol++;
            ps  = sclk;
            psi = si;
            if (done) begin
                got_done = 1'b1;
                sh = shadow_addr;
                chk($sformatf("v%0d_busy_in_done", idx), busy, 0);
                break;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), got_done, 1);
        chk($sformatf("v%0d_nbits", idx), nbits, v.exp_nbits);
        chk($sformatf("v%0d_bits", idx), bits, v.exp_bits);
        chk($sformatf("v%0d_busy_cycles", idx), busy_c, v.exp_busy);
        chk($sformatf("v%0d_counter_low", idx), ctr_c, v.exp_ctr);
        chk($sformatf("v%0d_sreg_en_low", idx), en_c, v.exp_en);
        chk($sformatf("v%0d_si_stable", idx), viol, 0);
        chk($sformatf("v%0d_shadow", idx), sh, shadow_exp(v.exp_shadow));
        @(negedge clk);
        chk($sformatf("v%0d_done_single", idx), {busy, done}, 2'b00);
    endtask

    initial begin
        vec_t        rv;
        int          nb;
        logic        ps;
        logic        nodone;
        logic [20:0] a1 [2];
        int          busy_c, en_c, ctr_c;
        logic [20:0] bits;
        logic        got;

        vecs[0] = '{st:1'b1, in:1'b0, addr:21'h155AA5, repulse:-1, exp_bits:21'h155AA5,
                    exp_nbits:21, exp_busy:172, exp_ctr:0, exp_en:172, exp_shadow:21'h155AA5};
        vecs[1] = '{st:1'b0, in:1'b1, addr:21'h000000, repulse:-1, exp_bits:21'h000000,
                    exp_nbits:0, exp_busy:4, exp_ctr:4, exp_en:0, exp_shadow:21'h155AA6};
        vecs[2] = '{st:1'b1, in:1'b1, addr:21'h0A5F0F, repulse:-1, exp_bits:21'h0A5F0F,
                    exp_nbits:21, exp_busy:172, exp_ctr:0, exp_en:172, exp_shadow:21'h0A5F0F};
        vecs[3] = '{st:1'b1, in:1'b0, addr:21'h1FFFFF, repulse:-1, exp_bits:21'h1FFFFF,
                    exp_nbits:21, exp_busy:172, exp_ctr:0, exp_en:172, exp_shadow:21'h1FFFFF};
        vecs[4] = '{st:1'b0, in:1'b1, addr:21'h123456, repulse:-1, exp_bits:21'h000000,
                    exp_nbits:0, exp_busy:4, exp_ctr:4, exp_en:0, exp_shadow:21'h000000};
        vecs[5] = '{st:1'b1, in:1'b0, addr:21'h000001, repulse:50, exp_bits:21'h000001,
                    exp_nbits:21, exp_busy:172, exp_ctr:0, exp_en:172, exp_shadow:21'h000001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, si, sclk, sreg_en_n, counter_n}, 6'b000011);
        chk("reset_shadow", shadow_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset asserted at bit 10 of a shift
        @(negedge clk);
        start = 1'b1;
        addr  = 21'h155AA5;
        nb = 0;
        ps = 1'b0;
        for (int cyc = 0; cyc < 400 && nb < 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (sclk && !ps) nb++;
            ps = sclk;
        end
        chk("rst_mid_reached_bit10", nb, 10);
        #1 reset_n = 1'b0;
        #1 chk("rst_mid_outputs", {busy, done, si, sclk, sreg_en_n, counter_n}, 6'b000011);
        nodone = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) nodone = 1'b0;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) nodone = 1'b0;
        end
        chk("rst_mid_no_done", nodone, 1);
        rv = '{st:1'b1, in:1'b0, addr:21'h0F0F33, repulse:-1, exp_bits:21'h0F0F33,
               exp_nbits:21, exp_busy:172, exp_ctr:0, exp_en:172, exp_shadow:21'h0F0F33};
        run_txn(rv, 9);

        // DIV=1 instance: back-to-back transfers
        a1[0] = 21'h012345;
        a1[1] = 21'h0ABCDE;
        @(negedge clk);
        start1 = 1'b1;
        addr1  = a1[0];
        for (int t = 0; t < 2; t++) begin
            busy_c = 0; en_c = 0; ctr_c = 0; nb = 0; bits = '0; ps = 1'b0; got = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                @(negedge clk);
                start1 = 1'b0;
                addr1  = 21'h1FFFFF;
                if (busy1) busy_c++;
                if (!sreg_en_n1) en_c++;
                if (!counter_n1) ctr_c++;
                if (sclk1 && !ps) begin
                    bits = {bits[19:0], si1};
                    nb++;
                end
                ps = sclk1;
                if (done1) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("div1_t%0d_done_seen", t), got, 1);
            chk($sformatf("div1_t%0d_busy_cycles", t), busy_c, 43);
            chk($sformatf("div1_t%0d_sreg_en_low", t), en_c, 43);
            chk($sformatf("div1_t%0d_counter_low", t), ctr_c, 0);
            chk($sformatf("div1_t%0d_nbits", t), nb, 21);
            chk($sformatf("div1_t%0d_bits", t), bits, a1[t]);
            if (t == 0) begin
                start1 = 1'b1;
                addr1  = a1[1];
                @(negedge clk);
                chk("div1_idle_gap", {busy1, done1}, 2'b00);
            end
        end
        chk("div1_shadow", shadow_addr1, shadow_exp(a1[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
